// File: rtl/alu_ram_cpu.sv
// Accumulator processor: combinational ALU, single-port synchronous word RAM
// and a fetch/latch/exec/mem FSM, with an external RAM port used while idle or halted.

module alu_ram_cpu_alu (
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        y = '0;
        case (ctrl)
            4'b0000: y = a & b;
            4'b0001: y = a | b;
            4'b0010: y = a + b;
            4'b0110: y = a - b;
            4'b0111: y = {31'b0, (a_s < b_s)};
            4'b1100: y = ~(a | b);
            default: y = '0;
        endcase
    end
endmodule

module alu_ram_cpu #(
    parameter int ADDR_WIDTH = 10,
    parameter int START_PC   = 'h100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [31:0]           ext_wdata,
    output logic [31:0]           ext_rdata,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           acc,
    output logic                  halted,
    output logic                  busy,
    output logic                  store_valid,
    output logic [ADDR_WIDTH-1:0] store_addr,
    output logic [31:0]           store_data
);
    localparam logic [ADDR_WIDTH-1:0] PC_INIT = START_PC[ADDR_WIDTH-1:0];

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_HALT  = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;
    localparam logic [3:0] OP_CLEAR = 4'd4;
    localparam logic [3:0] OP_SKIP  = 4'd5;
    localparam logic [3:0] OP_JUMP  = 4'd6;
    localparam logic [3:0] OP_ADDI  = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_EXEC, S_MEM, S_HALTED
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [31:0]           acc_q;
    logic [31:0]           ir;
    logic [31:0]           rd_q;
    logic [31:0]           mem [2**ADDR_WIDTH];

    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] ea;
    logic [7:0]            imm;
    logic signed [31:0]    acc_s;
    logic                  skip;
    logic                  ext_own;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           alu_b;
    logic [31:0]           alu_y;
    logic                  unused_ir;

    assign opcode    = ir[31:28];
    assign ea        = ir[ADDR_WIDTH-1:0];
    assign imm       = ir[27:20];
    assign acc_s     = acc_q;
    assign unused_ir = ^ir[27:0];
    assign ext_own   = (state == S_IDLE) || (state == S_HALTED);

    // ADD and ADDI share one adder; MEM supplies the RAM word, EXEC the immediate
    assign alu_b = (state == S_MEM) ? rd_q : {24'b0, imm};

    alu_ram_cpu_alu u_alu (
        .ctrl (4'b0010),
        .a    (acc_q),
        .b    (alu_b),
        .y    (alu_y)
    );

    always_comb begin
        skip = 1'b0;
        case (ir[2:0])
            3'b010:  skip = (acc_q == '0);
            3'b000:  skip = (acc_s < 32'sd0);
            3'b100:  skip = (acc_s > 32'sd0);
            default: skip = 1'b0;
        endcase
    end

    always_comb begin
        ram_addr  = ext_addr;
        ram_we    = 1'b0;
        ram_wdata = ext_wdata;
        if (ext_own) begin
            ram_we = ext_we;
        end else begin
            case (state)
                S_FETCH: ram_addr = pc_q;
                S_EXEC: begin
                    ram_addr  = ea;
                    ram_we    = (opcode == OP_STORE);
                    ram_wdata = acc_q;
                end
                default: ram_addr = ext_addr;
            endcase
        end
    end

    // RAM array; a write racing with reset is dropped
    always_ff @(posedge clk) begin
        if (ram_we && !rst)
            mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_q <= '0;
        else
            rd_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_LATCH;
            S_LATCH:  state_nxt = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_LOAD: state_nxt = S_MEM;
                    OP_HALT:         state_nxt = S_HALTED;
                    default:         state_nxt = S_FETCH;
                endcase
            end
            S_MEM:    state_nxt = S_FETCH;
            S_HALTED: if (!run) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= PC_INIT;
            acc_q <= '0;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: if (run) pc_q <= PC_INIT;
                S_LATCH: begin
                    ir   <= rd_q;
                    pc_q <= pc_q + 1'b1;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_HALT:  pc_q  <= pc_q - 1'b1;
                        OP_CLEAR: acc_q <= '0;
                        OP_SKIP:  if (skip) pc_q <= pc_q + 1'b1;
                        OP_JUMP:  pc_q  <= ea;
                        OP_ADDI:  acc_q <= alu_y;
                        default:  ;
                    endcase
                end
                S_MEM: acc_q <= (opcode == OP_LOAD) ? rd_q : alu_y;
                default: ;
            endcase
        end
    end

    assign ext_rdata   = rd_q;
    assign pc          = pc_q;
    assign acc         = acc_q;
    assign halted      = (state == S_HALTED);
    assign busy        = (state == S_FETCH) || (state == S_LATCH) ||
                         (state == S_EXEC)  || (state == S_MEM);
    assign store_valid = (state == S_EXEC) && (opcode == OP_STORE);
    assign store_addr  = store_valid ? ea : '0;
    assign store_data  = store_valid ? acc_q : '0;
endmodule

// File: tb/tb_alu_ram_cpu.sv
// Directed bench for alu_ram_cpu: reset, external RAM port, small programs and the ALU.

module tb_alu_ram_cpu;
    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        ext_we;
    logic [9:0]  ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic [9:0]  pc;
    logic [31:0] acc;
    logic        halted;
    logic        busy;
    logic        store_valid;
    logic [9:0]  store_addr;
    logic [31:0] store_data;

    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;

    int tests = 0;
    int fails = 0;
    int st_cnt;
    logic [9:0]  st_addr;
    logic [31:0] st_data;
    int cyc;
    logic [31:0] alu_exp [16];

    always #5 clk = ~clk;

    alu_ram_cpu dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_rdata   (ext_rdata),
        .pc          (pc),
        .acc         (acc),
        .halted      (halted),
        .busy        (busy),
        .store_valid (store_valid),
        .store_addr  (store_addr),
        .store_data  (store_data)
    );

    alu_ram_cpu_alu u_alu (
        .ctrl (alu_ctrl),
        .a    (alu_a),
        .b    (alu_b),
        .y    (alu_y)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        ext_addr  = a;
        ext_wdata = d;
        ext_we    = 1'b1;
        tick;
        ext_we    = 1'b0;
    endtask

    // Raise run, then count edges after the sampling edge until HALTED
    task automatic go(input int budget, output int n);
        run = 1'b1;
        tick;
        check("busy_after_run", {31'b0, busy}, 32'd1);
        n = 0;
        st_cnt = 0;
        st_addr = '0;
        st_data = '0;
        while (halted !== 1'b1 && n < budget) begin
            tick;
            n++;
            if (store_valid === 1'b1) begin
                st_cnt++;
                st_addr = store_addr;
                st_data = store_data;
            end
        end
        check("halt_reached", {31'b0, halted}, 32'd1);
    endtask

    task automatic stop_run;
        run = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        alu_ctrl = '0; alu_a = '0; alu_b = '0;
        tick; tick;
        rst = 1'b0;
        tick;
        check("rst_pc", {22'b0, pc}, 32'h100);
        check("rst_acc", acc, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_store_valid", {31'b0, store_valid}, 32'd0);
        check("rst_store_addr", {22'b0, store_addr}, 32'd0);
        check("rst_store_data", store_data, 32'd0);
        check("rst_ext_rdata", ext_rdata, 32'd0);

        wr(10'h005, 32'hDEADBEEF);
        tick;
        check("ext_rdback", ext_rdata, 32'hDEADBEEF);

        // Straight-line: LOAD, ADD, ADDI 5, STORE, HALT
        wr(10'h100, 32'h20000110);
        wr(10'h101, 32'h00000111);
        wr(10'h102, 32'h70500000);
        wr(10'h103, 32'h30000112);
        wr(10'h104, 32'h10000000);
        wr(10'h110, 32'd7);
        wr(10'h111, 32'hFFFFFFFE);
        wr(10'h112, 32'h0);
        go(100, cyc);
        check("line_cycles", cyc, 32'd17);
        check("line_acc", acc, 32'h0A);
        check("line_pc", {22'b0, pc}, 32'h104);
        check("line_store_cnt", st_cnt, 32'd1);
        check("line_store_addr", {22'b0, st_addr}, 32'h112);
        check("line_store_data", st_data, 32'h0A);
        check("line_busy_halted", {31'b0, busy}, 32'd0);
        tick;
        check("line_stay_halted", {31'b0, halted}, 32'd1);
        stop_run;
        check("line_idle", {31'b0, halted}, 32'd0);
        ext_addr = 10'h112;
        tick;
        check("line_mem112", ext_rdata, 32'h0A);

        // Countdown loop: ADD -1 until zero, SKIP 010 over JUMP back
        wr(10'h100, 32'h40000000);
        wr(10'h101, 32'h70300000);
        wr(10'h102, 32'h00000120);
        wr(10'h103, 32'h50000002);
        wr(10'h104, 32'h60000102);
        wr(10'h105, 32'h10000000);
        wr(10'h120, 32'hFFFFFFFF);
        go(200, cyc);
        check("loop_acc", acc, 32'h0);
        check("loop_pc", {22'b0, pc}, 32'h105);
        check("loop_cycles", cyc, 32'd36);
        stop_run;

        // Signed skips on AC = 0x80000000
        wr(10'h100, 32'h20000121);
        wr(10'h101, 32'h50000000);
        wr(10'h102, 32'h10000000);
        wr(10'h103, 32'h50000004);
        wr(10'h104, 32'h10000000);
        wr(10'h105, 32'h10000000);
        wr(10'h121, 32'h80000000);
        go(100, cyc);
        check("skip_acc", acc, 32'h80000000);
        check("skip_pc", {22'b0, pc}, 32'h104);
        stop_run;

        // Wrap: LOAD -1, ADDI 1, JUMP 3FF, NOP at 3FF, HALT at 000
        wr(10'h100, 32'h20000122);
        wr(10'h101, 32'h70100000);
        wr(10'h102, 32'h600003FF);
        wr(10'h122, 32'hFFFFFFFF);
        wr(10'h3FF, 32'h80000000);
        wr(10'h000, 32'h10000000);
        go(100, cyc);
        check("wrap_acc", acc, 32'h0);
        check("wrap_pc", {22'b0, pc}, 32'h000);
        check("wrap_cycles", cyc, 32'd16);
        stop_run;

        // Asynchronous reset while the STORE is in EXEC
        wr(10'h100, 32'h20000110);
        wr(10'h101, 32'h00000111);
        wr(10'h102, 32'h70500000);
        wr(10'h103, 32'h30000112);
        wr(10'h104, 32'h10000000);
        wr(10'h112, 32'h0);
        run = 1'b1;
        tick;
        repeat (13) tick;
        check("abort_store_valid", {31'b0, store_valid}, 32'd1);
        check("abort_acc_before", acc, 32'h0A);
        #1;
        rst = 1'b1;
        run = 1'b0;
        #1;
        check("abort_pc", {22'b0, pc}, 32'h100);
        check("abort_acc", acc, 32'h0);
        check("abort_halted", {31'b0, halted}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_store_valid_clr", {31'b0, store_valid}, 32'd0);
        tick;
        rst = 1'b0;
        tick;
        ext_addr = 10'h112;
        tick;
        check("abort_mem112", ext_rdata, 32'h0);

        // ALU standalone
        alu_exp = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                    32'h0, 32'h0, 32'hE1E1E1E1, 32'h1,
                    32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0};
        alu_a = 32'hF0F0F0F0;
        alu_b = 32'h0F0F0F0F;
        for (int c = 0; c < 16; c++) begin
            alu_ctrl = 4'(c);
            #1;
            check($sformatf("alu_c%0d", c), alu_y, alu_exp[c]);
        end
        alu_a = 32'd5; alu_b = 32'd3;
        alu_ctrl = 4'b0000; #1; check("alu_and_5_3", alu_y, 32'd1);
        alu_ctrl = 4'b0001; #1; check("alu_or_5_3", alu_y, 32'd7);
        alu_ctrl = 4'b0010; #1; check("alu_add_5_3", alu_y, 32'd8);
        alu_ctrl = 4'b0110; #1; check("alu_sub_5_3", alu_y, 32'd2);
        alu_ctrl = 4'b0111; #1; check("alu_slt_5_3", alu_y, 32'd0);
        alu_ctrl = 4'b1100; #1; check("alu_nor_5_3", alu_y, 32'hFFFFFFF8);
        alu_a = 32'hFFFFFFFF; alu_b = 32'd1;
        alu_ctrl = 4'b0111; #1; check("alu_slt_signed", alu_y, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
